mmu_map_sequencer: RTL
======================

MMU_MAP_SEQUENCER -- requirements
Module: mmu_map_sequencer

Interface
REQ-001 SHALL have ports: CLKX4  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: RESET  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: REG_SEL  in  2  register select; REG_WR  in  1  one-cycle write strobe; REG_DATA_in  in  8  write data; REG_DATA_out  out  8  read data, combinational from REG_SEL.
REQ-004 SHALL have: RAM_FREE  in  1  high when the CPU side is not using the MMU RAM this cycle.
REQ-005 SHALL have: MMU_ADDR  out  8  {key[4:0], idx[2:0]}; MMU_nRD  out  1; MMU_nWR  out  1; MMU_DATA_in  in  8; MMU_DATA_out  out  8; MMU_DATA_oe  out  1.
REQ-006 SHALL have: OWN  out  1  engine drives MMU RAM this cycle; BUSY  out  1; DONE  out  1  sticky completion flag.

Function
REQ-007 Registers: 0 CTRL, 1 SRC key[4:0], 2 DST key[4:0], 3 FILL byte; SRC/DST read back with bits 7:5 = 0.
REQ-008 CTRL write: bit0 START, bit1 MODE (0 copy, 1 fill), bit6 ABORT, bit7 CLEAR_DONE; CTRL read = {DONE, BUSY, 5'b0, MODE}.
REQ-009 States: IDLE, RD, WR, FIN.
REQ-010 IDLE + START write (ABORT=0) -> idx=0, MODE latched, DONE cleared; next state RD (copy) or WR (fill); BUSY=1 from next cycle.
REQ-011 START while BUSY SHALL be ignored; SRC/DST/FILL writes while BUSY SHALL be ignored.
REQ-012 RD with RAM_FREE=1: OWN=1, MMU_nRD=0, MMU_ADDR={SRC,idx}; MMU_DATA_in captured into buffer at that edge; next WR.
REQ-013 WR with RAM_FREE=1: OWN=1, MMU_nWR=0, MMU_DATA_oe=1, MMU_ADDR={DST,idx}, MMU_DATA_out = buffer (copy) or FILL (fill).
REQ-014 WR completion: idx=7 -> FIN; else idx+1, next RD (copy) or WR (fill); idx never wraps within a job.
REQ-015 Any state with RAM_FREE=0: OWN=0, MMU_nRD=1, MMU_nWR=1, MMU_DATA_oe=0; state and idx held; access retried on next free cycle.
REQ-016 Strobes SHALL be asserted only in cycles where OWN=1; when OWN=0, MMU_ADDR=0, MMU_DATA_out=0.
REQ-017 FIN: DONE=1, BUSY=0 next cycle, return to IDLE; FIN lasts one cycle regardless of RAM_FREE.
REQ-018 Latency with RAM_FREE held high: copy = 16 access cycles + FIN (BUSY high 17 cycles); fill = 8 + FIN (9 cycles).
REQ-019 ABORT write in any state -> IDLE next edge, strobes deasserted same cycle as abort registered, DONE unchanged, partial writes not undone.
REQ-020 CLEAR_DONE clears DONE; CLEAR_DONE with START in same write: START wins, DONE=0.
REQ-021 FIN with CLEAR_DONE write same cycle: DONE set (set wins).
REQ-022 SRC=DST copy SHALL be allowed and rewrite identical values.
REQ-023 Outputs SHALL be registered state-decoded; no combinational path from RAM_FREE to MMU_ADDR except gating of OWN/strobes/oe.

Reset
REQ-024 RESET high SHALL asynchronously force IDLE, idx=0, SRC=DST=FILL=0, MODE=0, buffer=0, BUSY=0, DONE=0, OWN=0, MMU_nRD=1, MMU_nWR=1, MMU_DATA_oe=0.
REQ-025 RESET mid-job SHALL abandon the job with no further RAM strobes after reset assertion.

Verification
REQ-026 Copy: SRC=3, DST=5, RAM source 0x18..0x1F = A0..A7, RAM_FREE=1, START -> writes A0..A7 to 0x28..0x2F in order, BUSY 17 cycles, DONE=1, CTRL reads 0x80.
REQ-027 Fill: DST=31, FILL=0x5A, MODE=1 START -> 8 writes of 0x5A to 0xF8..0xFF, no MMU_nRD pulse, BUSY 9 cycles.
REQ-028 Stall: copy with RAM_FREE low every other cycle -> same RAM result, OWN=0 and strobes high on every stalled cycle, BUSY 33 cycles.
REQ-029 Abort: ABORT after 3rd write of fill -> exactly 3 entries modified, IDLE, DONE=0, BUSY=0.
REQ-030 Reset mid-copy (after 4 writes) -> all outputs at REQ-024 values immediately, registers read 0x00.
REQ-031 START while BUSY and DST write while BUSY -> ignored, original job completes unchanged.

Source files
------------

// File: rtl/mmu_map_sequencer.sv
// mmu_map_sequencer
// Purpose: block engine for the MMU map RAM. It copies one 8-entry block
// ({key, idx}) to another block, or fills a block with a constant byte. It
// uses only the RAM cycles that the CPU side leaves free.
// Ports:
//   CLKX4, RESET           clock (rising edge), asynchronous active-high reset
//   REG_SEL, REG_WR        register select and one-cycle write strobe
//   REG_DATA_in/out        register write data / combinational read data
//                          (0 CTRL, 1 SRC key, 2 DST key, 3 FILL byte)
//   RAM_FREE               CPU side is not using the MMU RAM this cycle
//   MMU_ADDR               {key[4:0], idx[2:0]}; zero when the engine does not own the RAM
//   MMU_nRD, MMU_nWR       active-low RAM strobes
//   MMU_DATA_in/out, _oe   RAM read data, write data and write-data enable
//   OWN, BUSY, DONE        engine drives RAM this cycle / job active / sticky completion

module mmu_map_sequencer (
   input  logic       CLKX4,
   input  logic       RESET,
   input  logic [1:0] REG_SEL,
   input  logic       REG_WR,
   input  logic [7:0] REG_DATA_in,
   output logic [7:0] REG_DATA_out,
   input  logic       RAM_FREE,
   output logic [7:0] MMU_ADDR,
   output logic       MMU_nRD,
   output logic       MMU_nWR,
   input  logic [7:0] MMU_DATA_in,
   output logic [7:0] MMU_DATA_out,
   output logic       MMU_DATA_oe,
   output logic       OWN,
   output logic       BUSY,
   output logic       DONE
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   localparam logic [1:0] SEL_CTRL = 2'd0;
   localparam logic [1:0] SEL_SRC  = 2'd1;
   localparam logic [1:0] SEL_DST  = 2'd2;
   localparam logic [1:0] SEL_FILL = 2'd3;

   logic [1:0] r_state;
   logic [2:0] r_idx;
   logic [4:0] r_src;
   logic [4:0] r_dst;
   logic [7:0] r_fill;
   logic [7:0] r_buf;
   logic       r_mode;
   logic       r_done;

   logic w_idle;
   logic w_ctrl_wr;
   logic w_abort;
   logic w_start;
   logic w_clear;
   logic w_access;
   logic w_go;
   logic w_rd_go;
   logic w_wr_go;

   assign w_idle    = (r_state == S_IDLE);
   assign w_ctrl_wr = REG_WR && (REG_SEL == SEL_CTRL);
   assign w_abort   = w_ctrl_wr && REG_DATA_in[6];
   // START only counts from IDLE, and ABORT in the same write cancels it.
   assign w_start   = w_ctrl_wr && REG_DATA_in[0] && !REG_DATA_in[6] && w_idle;
   assign w_clear   = w_ctrl_wr && REG_DATA_in[7];

   // RAM_FREE and ABORT only gate the access. The address and data come from registers.
   // An ABORT write removes the strobes in the same cycle that it is seen.
   assign w_access = (r_state == S_RD) || (r_state == S_WR);
   assign w_go     = w_access && RAM_FREE && !w_abort;
   assign w_rd_go  = w_go && (r_state == S_RD);
   assign w_wr_go  = w_go && (r_state == S_WR);

   assign OWN          = w_go;
   assign MMU_nRD      = !w_rd_go;
   assign MMU_nWR      = !w_wr_go;
   assign MMU_DATA_oe  = w_wr_go;
   assign MMU_ADDR     = w_rd_go ? {r_src, r_idx} :
                         w_wr_go ? {r_dst, r_idx} : 8'h00;
   assign MMU_DATA_out = w_wr_go ? (r_mode ? r_fill : r_buf) : 8'h00;
   assign BUSY         = !w_idle;
   assign DONE         = r_done;

   always_comb begin
      // NOTE: assign a default before the case so that every path drives the output; without it a latch is inferred.
      REG_DATA_out = 8'h00;
      case (REG_SEL)
         SEL_CTRL: REG_DATA_out = {r_done, BUSY, 5'b00000, r_mode};
         SEL_SRC:  REG_DATA_out = {3'b000, r_src};
         SEL_DST:  REG_DATA_out = {3'b000, r_dst};
         SEL_FILL: REG_DATA_out = r_fill;
         default:  REG_DATA_out = 8'h00;
      endcase
   end

   // Job sequencer
   always_ff @(posedge CLKX4 or posedge RESET) begin
      if (RESET) begin
         // NOTE: sequential state uses non-blocking assignments so that every register samples values from before the edge.
         r_state <= S_IDLE;
         r_idx   <= 3'd0;
         r_mode  <= 1'b0;
         r_buf   <= 8'h00;
      end else if (w_abort) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_idx   <= 3'd0;
                  r_mode  <= REG_DATA_in[1];
                  r_state <= REG_DATA_in[1] ? S_WR : S_RD;
               end
            end
            S_RD: begin
               if (RAM_FREE) begin
                  r_buf   <= MMU_DATA_in;
                  r_state <= S_WR;
               end
            end
            S_WR: begin
               if (RAM_FREE) begin
                  // idx stops at 7 and does not wrap; the job ends through FIN.
                  if (r_idx == 3'd7) begin
                     r_state <= S_FIN;
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     r_state <= r_mode ? S_WR : S_RD;
                  end
               end
            end
            default: r_state <= S_IDLE;   // FIN always lasts exactly one cycle
         endcase
      end
   end

   // Configuration registers. They are frozen while a job runs.
   always_ff @(posedge CLKX4 or posedge RESET) begin
      if (RESET) begin
         r_src  <= 5'd0;
         r_dst  <= 5'd0;
         r_fill <= 8'h00;
      end else if (REG_WR && w_idle) begin
         case (REG_SEL)
            SEL_SRC:  r_src  <= REG_DATA_in[4:0];
            SEL_DST:  r_dst  <= REG_DATA_in[4:0];
            SEL_FILL: r_fill <= REG_DATA_in;
            default:  ;
         endcase
      end
   end

   // Sticky DONE. Completion has priority over CLEAR_DONE in the FIN cycle.
   // An abort leaves DONE unchanged.
   always_ff @(posedge CLKX4 or posedge RESET) begin
      if (RESET) begin
         r_done <= 1'b0;
      end else if ((r_state == S_FIN) && !w_abort) begin
         r_done <= 1'b1;
      end else if (w_start || w_clear) begin
         r_done <= 1'b0;
      end
   end

endmodule
